// File: rtl/pool_pkg.sv
// Shared types and defaults for the 2x2 max-pool layer sequencer.
package pool_pkg;
  localparam int POOL_PARALLELISM_DEF = 8;
  localparam int ADDR_WIDTH_DEF       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_e;
endpackage

// File: rtl/pool_sched_if.sv
// Control, feature-memory read and pooled-write signals of the pool sequencer.
interface pool_sched_if import pool_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();
  logic                  start;
  logic [7:0]            input_size;
  logic [7:0]            channel;
  logic [ADDR_WIDTH-1:0] in_base;
  logic [ADDR_WIDTH-1:0] out_base;
  logic                  hold;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic                  pool_en;
  logic                  row_odd;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  modport master (
    output start, input_size, channel, in_base, out_base, hold,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, pool_en, row_odd, wr_en, wr_addr
  );

  modport slave (
    input  start, input_size, channel, in_base, out_base, hold,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, pool_en, row_odd, wr_en, wr_addr
  );
endinterface

// File: rtl/pool_addr_gen.sv
// h/wp/cg walk over the input map with registered read-pair and pooled-write addresses.
module pool_addr_gen import pool_pkg::*; #(
  parameter int POOL_PARALLELISM = POOL_PARALLELISM_DEF,
  parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [7:0]            input_size,
  input  logic [7:0]            channel,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic                  last,
  output logic                  h_lsb,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [ADDR_WIDTH-1:0] wr_addr
);
  logic [7:0] size_q, ng_q, h_q, wp_q, cg_q;
  logic [7:0] ng_d, h_d, wp_d, cg_d, half;
  logic [ADDR_WIDTH-1:0] in_base_q, out_base_q, ng_w, rd_off, wr_off;

  assign ng_d = (channel / 8'(POOL_PARALLELISM)) +
                8'((channel % 8'(POOL_PARALLELISM)) != 8'd0);
  assign half  = size_q >> 1;
  assign last  = (h_q == size_q - 8'd1) && (wp_q == half - 8'd1) && (cg_q == ng_q - 8'd1);
  assign h_lsb = h_q[0];

  // cg is innermost, then wp, then h
  always_comb begin
    h_d  = h_q;
    wp_d = wp_q;
    cg_d = cg_q + 8'd1;
    if (cg_q == ng_q - 8'd1) begin
      cg_d = '0;
      wp_d = wp_q + 8'd1;
      if (wp_q == half - 8'd1) begin
        wp_d = '0;
        h_d  = h_q + 8'd1;
      end
    end
  end

  assign ng_w   = ADDR_WIDTH'(ng_q);
  assign rd_off = (ADDR_WIDTH'(h_d) * ADDR_WIDTH'(size_q) + ADDR_WIDTH'({wp_d, 1'b0})) * ng_w
                  + ADDR_WIDTH'(cg_d);
  assign wr_off = (ADDR_WIDTH'(h_d >> 1) * ADDR_WIDTH'(half) + ADDR_WIDTH'(wp_d)) * ng_w
                  + ADDR_WIDTH'(cg_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q     <= '0;
      ng_q       <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      h_q        <= '0;
      wp_q       <= '0;
      cg_q       <= '0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      wr_addr    <= '0;
    end else if (load) begin
      size_q     <= input_size;
      ng_q       <= ng_d;
      in_base_q  <= in_base;
      out_base_q <= out_base;
      h_q        <= '0;
      wp_q       <= '0;
      cg_q       <= '0;
      rd_addr_a  <= in_base;
      rd_addr_b  <= in_base + ADDR_WIDTH'(ng_d);
      wr_addr    <= out_base;
    end else if (advance) begin
      h_q        <= h_d;
      wp_q       <= wp_d;
      cg_q       <= cg_d;
      rd_addr_a  <= in_base_q + rd_off;
      rd_addr_b  <= in_base_q + rd_off + ng_w;
      wr_addr    <= out_base_q + wr_off;
    end
  end
endmodule

// File: rtl/pool_sched.sv
// Layer sequencer for the 2x2 max-pool datapath: read issue, latency alignment, pooled writes.
// Optional: define POOL_SCHED_PERF_EN to add the perf_cycles busy-cycle counter output.
//
// state | meaning
// IDLE  | waiting for start, operands latched on accept
// ISSUE | one read pair per cycle unless hold
// DRAIN | waiting for in-flight reads to reach the write stage
// DONE  | one-cycle done pulse
module pool_sched import pool_pkg::*; #(
  parameter int POOL_PARALLELISM = POOL_PARALLELISM_DEF,
  parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
  parameter int RD_LAT           = 1,
  parameter int POOL_LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  pool_sched_if.slave bus
`ifdef POOL_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);
  localparam int WR_LAT = RD_LAT + POOL_LAT;

  pool_state_e state_q, state_d;
  logic accept, empty_layer, issue, last, h_lsb, busy;
  logic [ADDR_WIDTH-1:0] wr_addr_cur;
  logic [WR_LAT:1] vld_q, odd_q;
  logic [ADDR_WIDTH-1:0] waddr_q [1:WR_LAT];

  assign accept      = (state_q == IDLE) && bus.start;
  assign empty_layer = (bus.channel == 8'd0) || (bus.input_size < 8'd2);

  pool_addr_gen #(
    .POOL_PARALLELISM (POOL_PARALLELISM),
    .ADDR_WIDTH       (ADDR_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .advance    (issue && !last),
    .input_size (bus.input_size),
    .channel    (bus.channel),
    .in_base    (bus.in_base),
    .out_base   (bus.out_base),
    .last       (last),
    .h_lsb      (h_lsb),
    .rd_addr_a  (bus.rd_addr_a),
    .rd_addr_b  (bus.rd_addr_b),
    .wr_addr    (wr_addr_cur)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // An empty layer passes through DRAIN so done keeps the same start-to-done shape.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_d = empty_layer ? DRAIN : ISSUE;
      end
      ISSUE: begin
        issue = !bus.hold;
        if (issue && last) state_d = DRAIN;
      end
      DRAIN:   if (vld_q[WR_LAT-1:1] == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      odd_q <= '0;
      for (int k = 1; k <= WR_LAT; k++) waddr_q[k] <= '0;
    end else begin
      vld_q      <= {vld_q[WR_LAT-1:1], issue};
      odd_q      <= {odd_q[WR_LAT-1:1], issue && h_lsb};
      waddr_q[1] <= issue ? wr_addr_cur : '0;
      for (int k = 2; k <= WR_LAT; k++) waddr_q[k] <= waddr_q[k-1];
    end
  end

  assign bus.rd_en   = issue;
  assign bus.busy    = busy;
  assign bus.done    = (state_q == DONE);
  assign bus.pool_en = vld_q[RD_LAT];
  assign bus.row_odd = odd_q[RD_LAT];
  // even-row pairs only fill the datapath row buffer
  assign bus.wr_en   = vld_q[WR_LAT] && odd_q[WR_LAT];
  assign bus.wr_addr = bus.wr_en ? waddr_q[WR_LAT] : '0;

`ifdef POOL_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (busy)   perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pool_sched.sv
// Directed, table-driven bench for pool_sched (RD_LAT=1, POOL_LAT=2, POOL_PARALLELISM=8).
module tb_pool_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef POOL_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  pool_sched_if #(.ADDR_WIDTH(16)) bus ();

  pool_sched #(
    .POOL_PARALLELISM (8),
    .ADDR_WIDTH       (16),
    .RD_LAT           (1),
    .POOL_LAT         (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef POOL_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  size;
    logic [7:0]  ch;
    logic [15:0] inb;
    logic [15:0] outb;
    int hold_lo;
    int hold_hi;
    int extra_start;
    int exp_reads;
    int exp_writes;
    int exp_first_wr;
    int exp_done;
  } vec_t;

  localparam int NV = 10;
  localparam int MAXC = 64;
  vec_t vecs [NV];

  int nchk = 0;
  int nfail = 0;

  logic        rd_l [MAXC];
  logic [15:0] a_l  [MAXC];
  logic [15:0] b_l  [MAXC];
  logic        pe_l [MAXC];
  logic        ro_l [MAXC];
  logic        wr_l [MAXC];
  logic [15:0] wa_l [MAXC];
  logic        by_l [MAXC];
  logic        dn_l [MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"},    32'(bus.busy),      0);
    chk({tag, " done"},    32'(bus.done),      0);
    chk({tag, " rd_en"},   32'(bus.rd_en),     0);
    chk({tag, " rd_a"},    32'(bus.rd_addr_a), 0);
    chk({tag, " rd_b"},    32'(bus.rd_addr_b), 0);
    chk({tag, " pool_en"}, 32'(bus.pool_en),   0);
    chk({tag, " row_odd"}, 32'(bus.row_odd),   0);
    chk({tag, " wr_en"},   32'(bus.wr_en),     0);
    chk({tag, " wr_addr"}, 32'(bus.wr_addr),   0);
  endtask

  // Cycle 0 is the start cycle; inputs change 1ns after each rising edge, sampling at the falling edge.
  task automatic run_log(input vec_t v, input int ncyc);
    @(posedge clk); #1;
    for (int c = 0; c < ncyc; c++) begin
      bus.start      = (c == 0) || (v.extra_start > 0 && c == v.extra_start);
      bus.hold       = (c >= v.hold_lo) && (c <= v.hold_hi);
      bus.input_size = v.size;
      bus.channel    = v.ch;
      bus.in_base    = v.inb;
      bus.out_base   = v.outb;
      @(negedge clk);
      rd_l[c] = bus.rd_en;   a_l[c] = bus.rd_addr_a; b_l[c] = bus.rd_addr_b;
      pe_l[c] = bus.pool_en; ro_l[c] = bus.row_odd;
      wr_l[c] = bus.wr_en;   wa_l[c] = bus.wr_addr;
      by_l[c] = bus.busy;    dn_l[c] = bus.done;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic check_vec(input int vi, input vec_t v, input int ncyc);
    int ng, half, nrd, nexp, nwr, first_wr, h, wp, cg;
    logic exp_rd, exp_w, in_hold;
    logic exp_odd [MAXC];
    logic [15:0] ea;
    ng   = (int'(v.ch) + 7) / 8;
    half = int'(v.size) / 2;
    nrd = 0; nexp = 0; nwr = 0; first_wr = -1;
    for (int c = 0; c < ncyc; c++) begin
      exp_odd[c] = 1'b0;
      in_hold = (c >= v.hold_lo) && (c <= v.hold_hi);
      exp_rd  = (c >= 1) && !in_hold && (nexp < v.exp_reads);
      chk($sformatf("v%0d rd_en c%0d", vi, c), 32'(rd_l[c]), 32'(exp_rd));
      if (exp_rd) nexp++;
      if (rd_l[c] && ng > 0 && half > 0) begin
        cg = nrd % ng;
        wp = (nrd / ng) % half;
        h  = nrd / (ng * half);
        ea = 16'(int'(v.inb) + (h * int'(v.size) + 2 * wp) * ng + cg);
        chk($sformatf("v%0d rd_addr_a c%0d", vi, c), 32'(a_l[c]), 32'(ea));
        chk($sformatf("v%0d rd_addr_b c%0d", vi, c), 32'(b_l[c]), 32'(16'(ea + 16'(ng))));
        exp_odd[c] = h[0];
      end
      if (rd_l[c]) nrd++;
    end
    for (int c = 0; c < ncyc; c++) begin
      chk($sformatf("v%0d pool_en c%0d", vi, c), 32'(pe_l[c]), (c >= 1) ? 32'(rd_l[c-1]) : 0);
      if (c >= 1 && pe_l[c])
        chk($sformatf("v%0d row_odd c%0d", vi, c), 32'(ro_l[c]), 32'(exp_odd[c-1]));
      exp_w = (c >= 3) ? (rd_l[c-3] & exp_odd[c-3]) : 1'b0;
      chk($sformatf("v%0d wr_en c%0d", vi, c), 32'(wr_l[c]), 32'(exp_w));
      if (wr_l[c]) begin
        chk($sformatf("v%0d wr_addr c%0d", vi, c), 32'(wa_l[c]), 32'(16'(v.outb + 16'(nwr))));
        if (first_wr < 0) first_wr = c;
        nwr++;
      end
      chk($sformatf("v%0d busy c%0d", vi, c), 32'(by_l[c]), 32'((c >= 1) && (c <= v.exp_done)));
      chk($sformatf("v%0d done c%0d", vi, c), 32'(dn_l[c]), 32'(c == v.exp_done));
    end
    chk($sformatf("v%0d read count", vi),  32'(nrd), 32'(v.exp_reads));
    chk($sformatf("v%0d write count", vi), 32'(nwr), 32'(v.exp_writes));
    chk($sformatf("v%0d first write cycle", vi), 32'(first_wr), 32'(v.exp_first_wr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           size   ch      inb        outb     hlo hhi xst rds wrs fwr done
    vecs[0] = '{8'd4, 8'd8,  16'd0,     16'd100, -1, -2,  0,  8,  4,  6, 12};
    vecs[1] = '{8'd4, 8'd20, 16'd0,     16'd0,   -1, -2,  0, 24, 12, 10, 28};
    vecs[2] = '{8'd4, 8'd8,  16'd0,     16'd100,  3,  4,  0,  8,  4,  8, 14};
    vecs[3] = '{8'd4, 8'd0,  16'd0,     16'd100, -1, -2,  0,  0,  0, -1,  2};
    vecs[4] = '{8'd2, 8'd8,  16'd50,    16'd200, -1, -2,  0,  2,  1,  5,  6};
    vecs[5] = '{8'd6, 8'd9,  16'd1000,  16'd5,   -1, -2,  0, 36, 18, 10, 40};
    vecs[6] = '{8'd1, 8'd8,  16'd0,     16'd100, -1, -2,  0,  0,  0, -1,  2};
    vecs[7] = '{8'd2, 8'd8,  16'hFFFE,  16'hFFFF, -1, -2, 0,  2,  1,  5,  6};
    vecs[8] = '{8'd4, 8'd8,  16'd0,     16'd100, -1, -2,  5,  8,  4,  6, 12};
    vecs[9] = '{8'd4, 8'd8,  16'd0,     16'd100, -1, -2, 12,  8,  4,  6, 12};

    bus.start = 1'b0; bus.hold = 1'b0;
    bus.input_size = '0; bus.channel = '0; bus.in_base = '0; bus.out_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("after reset");

    for (int i = 0; i < NV; i++) begin
      run_log(vecs[i], vecs[i].exp_done + 5);
      check_vec(i, vecs[i], vecs[i].exp_done + 5);
`ifdef POOL_SCHED_PERF_EN
      if (i == 0) chk("perf_cycles layer 0", perf_cycles, 32'd12);
      if (i == 2) chk("perf_cycles with hold", perf_cycles, 32'd14);
`endif
    end

    // Reset during DRAIN of the basic layer: everything clears, no done follows.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.hold = 1'b0;
    bus.input_size = 8'd4; bus.channel = 8'd8; bus.in_base = 16'd0; bus.out_base = 16'd100;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("drain busy before reset", 32'(bus.busy), 1);
    chk("drain rd_en before reset", 32'(bus.rd_en), 0);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid-drain reset");
    @(posedge clk); #1;
    chk_idle_outputs("mid-drain reset held");
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset done c%0d", c), 32'(bus.done), 0);
      chk($sformatf("post-reset wr_en c%0d", c), 32'(bus.wr_en), 0);
      chk($sformatf("post-reset busy c%0d", c), 32'(bus.busy), 0);
    end
    run_log(vecs[0], vecs[0].exp_done + 5);
    check_vec(100, vecs[0], vecs[0].exp_done + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
